syn_fifo: RTL and testbench

//  Single-clock synchronous FIFO for the SNC core's buffering paths.

---
 rtl/syn_fifo_pkg.sv | 10 +
 rtl/syn_fifo_if.sv | 37 +++
 rtl/syn_fifo_ctrl.sv | 57 +++++
 rtl/syn_fifo.sv | 77 +++++++
 tb/tb_syn_fifo.sv | 214 +++++++++++++++++++++
 5 files changed

// File: rtl/syn_fifo_pkg.sv
// Purpose: shared defaults for the SNC single-clock FIFO.
// Latency: n/a (constants only).
// Backpressure: n/a.
package syn_fifo_pkg;

  // Default geometry; FIFO_ENTRIES must be a power of two and at least 2.
  localparam int DEF_FIFO_ENTRIES = 16;
  localparam int DEF_DATA_WIDTH   = 8;

endpackage

// File: rtl/syn_fifo_if.sv
// Purpose: write/read request bus and status of the SNC single-clock FIFO.
// Latency: n/a (wires only).
// Backpressure: full_o/empty_o tell the master when requests will be rejected.
// Ports: master drives wr_en_i/wr_data_i/rd_en_i; slave (the FIFO) drives
//        rd_data_o, wr_idx_o, rd_idx_o, count_o, full_o, empty_o, overflow_o, underflow_o.
interface syn_fifo_if
  import syn_fifo_pkg::*;
#(
  parameter int DATA_WIDTH = DEF_DATA_WIDTH,
  parameter int AW         = $clog2(DEF_FIFO_ENTRIES)
);

  logic                  wr_en_i;
  logic [DATA_WIDTH-1:0] wr_data_i;
  logic                  rd_en_i;
  logic [DATA_WIDTH-1:0] rd_data_o;
  logic [AW-1:0]         wr_idx_o;
  logic [AW-1:0]         rd_idx_o;
  logic [AW:0]           count_o;
  logic                  full_o;
  logic                  empty_o;
  logic                  overflow_o;
  logic                  underflow_o;

  modport master (
    output wr_en_i, wr_data_i, rd_en_i,
    input  rd_data_o, wr_idx_o, rd_idx_o, count_o,
    input  full_o, empty_o, overflow_o, underflow_o
  );

  modport slave (
    input  wr_en_i, wr_data_i, rd_en_i,
    output rd_data_o, wr_idx_o, rd_idx_o, count_o,
    output full_o, empty_o, overflow_o, underflow_o
  );

endinterface

// File: rtl/syn_fifo_ctrl.sv
// Purpose: pointer, fill-count and sticky-error bookkeeping for syn_fifo.
// Latency: accept strobes are combinational; pointers/count/errors update on the next edge.
// Backpressure: writes are refused while full, reads while empty (flagged sticky).
// Ports: sys_clk/sys_rstn; wr_en/rd_en requests in; wr_acc/rd_acc accept strobes,
//        wr_idx/rd_idx, count, full/empty and overflow/underflow out.
module syn_fifo_ctrl #(
  parameter  int FIFO_ENTRIES = 16,
  localparam int AW           = $clog2(FIFO_ENTRIES)
) (
  input  logic          sys_clk,
  input  logic          sys_rstn,
  input  logic          wr_en,
  input  logic          rd_en,
  output logic          wr_acc,
  output logic          rd_acc,
  output logic [AW-1:0] wr_idx,
  output logic [AW-1:0] rd_idx,
  output logic [AW:0]   count,
  output logic          full,
  output logic          empty,
  output logic          overflow,
  output logic          underflow
);

  localparam logic [AW:0] CNT_FULL = (AW+1)'(FIFO_ENTRIES);

  // Flags come from the registered count, so they reflect the pre-edge state
  // when a simultaneous read/write is resolved.
  assign full   = (count == CNT_FULL);
  assign empty  = (count == '0);
  assign wr_acc = wr_en & ~full;
  assign rd_acc = rd_en & ~empty;

  always_ff @(posedge sys_clk or negedge sys_rstn) begin
    if (!sys_rstn) begin
      wr_idx    <= '0;
      rd_idx    <= '0;
      count     <= '0;
      overflow  <= 1'b0;
      underflow <= 1'b0;
    end else begin
      // AW-bit pointers wrap from FIFO_ENTRIES-1 to 0 on their own.
      if (wr_acc) wr_idx <= wr_idx + AW'(1);
      if (rd_acc) rd_idx <= rd_idx + AW'(1);

      case ({wr_acc, rd_acc})
        2'b10:   count <= count + (AW+1)'(1);
        2'b01:   count <= count - (AW+1)'(1);
        default: count <= count;
      endcase

      if (wr_en && full)  overflow  <= 1'b1;
      if (rd_en && empty) underflow <= 1'b1;
    end
  end

endmodule

// File: rtl/syn_fifo.sv
// Purpose: single-clock synchronous FIFO for the SNC core buffering paths.
// Latency: one cycle from an accepted read request to rd_data_o.
// Backpressure: none asserted upstream; requests against full/empty are dropped and flagged.
// Ports: sys_clk, sys_rstn (async, active-low), bus (syn_fifo_if.slave carrying
//        wr_en_i/wr_data_i/rd_en_i in and rd_data_o, indices, count and flags out).
module syn_fifo
  import syn_fifo_pkg::*;
#(
  parameter  int FIFO_ENTRIES = DEF_FIFO_ENTRIES,
  parameter  int DATA_WIDTH   = DEF_DATA_WIDTH,
  localparam int AW           = $clog2(FIFO_ENTRIES)
) (
  input  logic       sys_clk,
  input  logic       sys_rstn,
  syn_fifo_if.slave  bus
);

  // Storage lives here (not in the controller) so dut.mem_array is reachable.
  logic [FIFO_ENTRIES-1:0][DATA_WIDTH-1:0] mem_array;
  logic [DATA_WIDTH-1:0]                   rd_data;

  logic          wr_acc;
  logic          rd_acc;
  logic [AW-1:0] wr_idx;
  logic [AW-1:0] rd_idx;
  logic [AW:0]   count;
  logic          full;
  logic          empty;
  logic          overflow;
  logic          underflow;

  syn_fifo_ctrl #(
    .FIFO_ENTRIES (FIFO_ENTRIES)
  ) u_ctrl (
    .sys_clk   (sys_clk),
    .sys_rstn  (sys_rstn),
    .wr_en     (bus.wr_en_i),
    .rd_en     (bus.rd_en_i),
    .wr_acc    (wr_acc),
    .rd_acc    (rd_acc),
    .wr_idx    (wr_idx),
    .rd_idx    (rd_idx),
    .count     (count),
    .full      (full),
    .empty     (empty),
    .overflow  (overflow),
    .underflow (underflow)
  );

  always_ff @(posedge sys_clk or negedge sys_rstn) begin
    if (!sys_rstn) begin
      mem_array <= '0;
    end else if (wr_acc) begin
      mem_array[wr_idx] <= bus.wr_data_i;
    end
  end

  // No write-to-read bypass: a read on an empty FIFO is refused even if a
  // write lands on the same edge, so rd_data holds its last value.
  always_ff @(posedge sys_clk or negedge sys_rstn) begin
    if (!sys_rstn) begin
      rd_data <= '0;
    end else if (rd_acc) begin
      rd_data <= mem_array[rd_idx];
    end
  end

  assign bus.rd_data_o   = rd_data;
  assign bus.wr_idx_o    = wr_idx;
  assign bus.rd_idx_o    = rd_idx;
  assign bus.count_o     = count;
  assign bus.full_o      = full;
  assign bus.empty_o     = empty;
  assign bus.overflow_o  = overflow;
  assign bus.underflow_o = underflow;

endmodule

// File: tb/tb_syn_fifo.sv
// Purpose: self-checking bench for syn_fifo (vector table plus directed sequences).
// Latency: checks rd_data_o one cycle after each accepted read.
// Backpressure: exercises full/empty rejection and the sticky error flags.
module tb_syn_fifo;

  localparam int N  = 16;
  localparam int DW = 8;
  localparam int AW = 4;

  logic clk = 1'b0;
  logic rstn;
  always #5 clk = ~clk;

  syn_fifo_if #(.DATA_WIDTH(DW), .AW(AW)) bus ();

  syn_fifo #(.FIFO_ENTRIES(N), .DATA_WIDTH(DW)) dut (
    .sys_clk  (clk),
    .sys_rstn (rstn),
    .bus      (bus)
  );

  typedef struct {
    logic          wr;
    logic [DW-1:0] d;
    logic          rd;
    logic [DW-1:0] exp_rd;
    logic [AW:0]   exp_cnt;
    logic [AW-1:0] exp_widx;
    logic [AW-1:0] exp_ridx;
    logic          exp_full;
    logic          exp_empty;
    logic          exp_ovf;
    logic          exp_unf;
  } vec_t;

  vec_t tbl [10];

  int n_cmp = 0;
  int n_err = 0;

  logic [DW-1:0] words [N];

  function automatic vec_t mk(input logic wr, input logic [DW-1:0] d, input logic rd,
                              input logic [DW-1:0] er, input logic [AW:0] ec,
                              input logic [AW-1:0] ew, input logic [AW-1:0] err_idx,
                              input logic ef, input logic ee, input logic eo, input logic eu);
    vec_t v;
    v.wr = wr; v.d = d; v.rd = rd; v.exp_rd = er; v.exp_cnt = ec;
    v.exp_widx = ew; v.exp_ridx = err_idx; v.exp_full = ef; v.exp_empty = ee;
    v.exp_ovf = eo; v.exp_unf = eu;
    return v;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Drive one request cycle; inputs change and outputs are sampled 1ns after the edge.
  task automatic step(input logic wr, input logic [DW-1:0] d, input logic rd);
    bus.wr_en_i   = wr;
    bus.wr_data_i = d;
    bus.rd_en_i   = rd;
    @(posedge clk);
    #1;
    bus.wr_en_i = 1'b0;
    bus.rd_en_i = 1'b0;
  endtask

  task automatic do_reset();
    rstn          = 1'b0;
    bus.wr_en_i   = 1'b0;
    bus.rd_en_i   = 1'b0;
    bus.wr_data_i = '0;
    repeat (3) @(posedge clk);
    #1;
    rstn = 1'b1;
  endtask

  initial begin
    logic [AW-1:0] wi, ri;
    logic [DW-1:0] w;

    // Hand-computed sequence from reset: simultaneous ops on empty and mid-level,
    // underflow on an empty read, idle cycles holding rd_data.
    tbl[0] = mk(1'b0, 8'h00, 1'b0, 8'h00, 5'd0, 4'd0, 4'd0, 1'b0, 1'b1, 1'b0, 1'b0);
    tbl[1] = mk(1'b1, 8'h11, 1'b1, 8'h00, 5'd1, 4'd1, 4'd0, 1'b0, 1'b0, 1'b0, 1'b1);
    tbl[2] = mk(1'b1, 8'h22, 1'b0, 8'h00, 5'd2, 4'd2, 4'd0, 1'b0, 1'b0, 1'b0, 1'b1);
    tbl[3] = mk(1'b1, 8'h33, 1'b1, 8'h11, 5'd2, 4'd3, 4'd1, 1'b0, 1'b0, 1'b0, 1'b1);
    tbl[4] = mk(1'b0, 8'h00, 1'b1, 8'h22, 5'd1, 4'd3, 4'd2, 1'b0, 1'b0, 1'b0, 1'b1);
    tbl[5] = mk(1'b0, 8'h00, 1'b1, 8'h33, 5'd0, 4'd3, 4'd3, 1'b0, 1'b1, 1'b0, 1'b1);
    tbl[6] = mk(1'b0, 8'h00, 1'b1, 8'h33, 5'd0, 4'd3, 4'd3, 1'b0, 1'b1, 1'b0, 1'b1);
    tbl[7] = mk(1'b1, 8'h44, 1'b0, 8'h33, 5'd1, 4'd4, 4'd3, 1'b0, 1'b0, 1'b0, 1'b1);
    tbl[8] = mk(1'b0, 8'h00, 1'b0, 8'h33, 5'd1, 4'd4, 4'd3, 1'b0, 1'b0, 1'b0, 1'b1);
    tbl[9] = mk(1'b0, 8'h00, 1'b1, 8'h44, 5'd0, 4'd4, 4'd4, 1'b0, 1'b1, 1'b0, 1'b1);

    // 1. Reset state
    do_reset();
    chk("rst_count", 32'(bus.count_o), 0);
    chk("rst_empty", 32'(bus.empty_o), 1);
    chk("rst_full", 32'(bus.full_o), 0);
    chk("rst_widx", 32'(bus.wr_idx_o), 0);
    chk("rst_ridx", 32'(bus.rd_idx_o), 0);
    chk("rst_rdata", 32'(bus.rd_data_o), 0);
    chk("rst_ovf", 32'(bus.overflow_o), 0);
    chk("rst_unf", 32'(bus.underflow_o), 0);

    // Vector table
    for (int i = 0; i < 10; i++) begin
      step(tbl[i].wr, tbl[i].d, tbl[i].rd);
      chk($sformatf("vec%0d_rd", i), 32'(bus.rd_data_o), 32'(tbl[i].exp_rd));
      chk($sformatf("vec%0d_cnt", i), 32'(bus.count_o), 32'(tbl[i].exp_cnt));
      chk($sformatf("vec%0d_widx", i), 32'(bus.wr_idx_o), 32'(tbl[i].exp_widx));
      chk($sformatf("vec%0d_ridx", i), 32'(bus.rd_idx_o), 32'(tbl[i].exp_ridx));
      chk($sformatf("vec%0d_full", i), 32'(bus.full_o), 32'(tbl[i].exp_full));
      chk($sformatf("vec%0d_empty", i), 32'(bus.empty_o), 32'(tbl[i].exp_empty));
      chk($sformatf("vec%0d_ovf", i), 32'(bus.overflow_o), 32'(tbl[i].exp_ovf));
      chk($sformatf("vec%0d_unf", i), 32'(bus.underflow_o), 32'(tbl[i].exp_unf));
    end

    // 2. Fill with 16 random words
    do_reset();
    for (int i = 0; i < N; i++) begin
      words[i] = DW'($urandom_range(0, 255));
      chk($sformatf("fill_widx%0d", i), 32'(bus.wr_idx_o), i);
      step(1'b1, words[i], 1'b0);
    end
    chk("fill_widx_wrap", 32'(bus.wr_idx_o), 0);
    chk("fill_full", 32'(bus.full_o), 1);
    chk("fill_count", 32'(bus.count_o), N);
    for (int i = 0; i < N; i++)
      chk($sformatf("fill_mem%0d", i), 32'(dut.mem_array[i]), 32'(words[i]));

    // 3. Drain in order, then one read too many
    for (int i = 0; i < N; i++) begin
      chk($sformatf("drain_ridx%0d", i), 32'(bus.rd_idx_o), i);
      step(1'b0, 8'h00, 1'b1);
      chk($sformatf("drain_rd%0d", i), 32'(bus.rd_data_o), 32'(words[i]));
    end
    chk("drain_empty", 32'(bus.empty_o), 1);
    chk("drain_unf_before", 32'(bus.underflow_o), 0);
    step(1'b0, 8'h00, 1'b1);
    chk("drain_unf", 32'(bus.underflow_o), 1);
    chk("drain_rd_hold", 32'(bus.rd_data_o), 32'(words[N-1]));
    chk("drain_ridx_hold", 32'(bus.rd_idx_o), 0);

    // 4. 48 write-one/read-one pairs, indices wrap three times
    do_reset();
    for (int i = 0; i < 48; i++) begin
      w  = DW'($urandom_range(0, 255));
      wi = bus.wr_idx_o;
      step(1'b1, w, 1'b0);
      ri = bus.rd_idx_o;
      step(1'b0, 8'h00, 1'b1);
      chk($sformatf("pair%0d_idx", i), 32'(ri), 32'(wi));
      chk($sformatf("pair%0d_slot", i), 32'(wi), i % N);
      chk($sformatf("pair%0d_rd", i), 32'(bus.rd_data_o), 32'(w));
    end
    chk("pair_widx_end", 32'(bus.wr_idx_o), 0);
    chk("pair_ridx_end", 32'(bus.rd_idx_o), 0);
    chk("pair_count_end", 32'(bus.count_o), 0);

    // 5. Overflow on a full FIFO, then simultaneous read+write while full
    do_reset();
    for (int i = 0; i < N; i++) begin
      words[i] = DW'(i * 3 + 1);
      step(1'b1, words[i], 1'b0);
    end
    step(1'b1, 8'hAA, 1'b0);
    chk("ovf_flag", 32'(bus.overflow_o), 1);
    chk("ovf_count", 32'(bus.count_o), N);
    chk("ovf_widx", 32'(bus.wr_idx_o), 0);
    for (int i = 0; i < N; i++)
      chk($sformatf("ovf_mem%0d", i), 32'(dut.mem_array[i]), 32'(words[i]));
    step(1'b1, 8'hBB, 1'b1);
    chk("fullrw_rd", 32'(bus.rd_data_o), 32'(words[0]));
    chk("fullrw_count", 32'(bus.count_o), N - 1);
    chk("fullrw_mem0", 32'(dut.mem_array[0]), 32'(words[0]));
    chk("fullrw_ovf_sticky", 32'(bus.overflow_o), 1);

    // Asynchronous reset mid-cycle clears everything without a clock edge
    #3;
    rstn = 1'b0;
    #1;
    chk("arst_count", 32'(bus.count_o), 0);
    chk("arst_empty", 32'(bus.empty_o), 1);
    chk("arst_ovf", 32'(bus.overflow_o), 0);
    chk("arst_mem1", 32'(dut.mem_array[1]), 0);
    chk("arst_rd", 32'(bus.rd_data_o), 0);

    // 6. Level 5, then 4 cycles of simultaneous read+write
    do_reset();
    for (int i = 0; i < 5; i++) step(1'b1, DW'(8'h10 + i), 1'b0);
    for (int i = 0; i < 4; i++) begin
      step(1'b1, DW'(8'h20 + i), 1'b1);
      chk($sformatf("rw%0d_rd", i), 32'(bus.rd_data_o), 32'h10 + i);
      chk($sformatf("rw%0d_count", i), 32'(bus.count_o), 5);
    end
    for (int i = 0; i < 5; i++) begin
      step(1'b0, 8'h00, 1'b1);
      chk($sformatf("rwdrain%0d_rd", i), 32'(bus.rd_data_o),
          (i == 0) ? 32'h14 : 32'h20 + i - 1);
    end
    chk("rw_empty", 32'(bus.empty_o), 1);
    chk("rw_unf", 32'(bus.underflow_o), 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
